// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: runs a req/ack handshake with data memory for
// the load/store in MEM, stalls the pipeline while it is outstanding, and bounds it with a timeout.
module mem_access_ctrl #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt,
  input  logic              flush,
  input  logic              MEM_mem_read,
  input  logic              MEM_mem_write,
  input  logic [DATA_W-1:0] MEM_ALU_result,
  input  logic [DATA_W-1:0] MEM_store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] MEM_mem_result,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                drop_q, drop_d;
  logic                start;
  logic                drop_eff;
  logic                stall;

  // Only the low ADDR_W bits of the effective address reach the memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^MEM_ALU_result[DATA_W-1:ADDR_W];

  assign start = (MEM_mem_read | MEM_mem_write) & ~hlt & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    stall    = 1'b0;
    drop_eff = drop_q | flush;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          stall   = 1'b1;
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = MEM_mem_write;
          addr_d  = MEM_ALU_result[ADDR_W-1:0];
          wdata_d = MEM_store_data;
          cnt_d   = '0;
          drop_d  = 1'b0;
        end
      end
      BUSY: begin
        stall  = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        drop_d = drop_eff;
        // A squashed access still finishes on the bus but never writes back or gets a DONE slot.
        if (mem_ack) begin
          req_d   = 1'b0;
          drop_d  = 1'b0;
          state_d = drop_eff ? IDLE : DONE;
          if (!we_q && !drop_eff) result_d = mem_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          drop_d  = 1'b0;
          err_d   = 1'b1;
          state_d = drop_eff ? IDLE : DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_req        = req_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign MEM_mem_result = result_q;
  assign mem_err        = err_q;
  assign mem_stall      = stall;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: per-cycle vector table plus hand sequences for timeout and reset.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        hlt, flush, rd, wr, ack;
  logic [31:0] alu, sdata, rdata;
  logic        req, we, stall, err;
  logic [21:0] addr;
  logic [31:0] wdata, result;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.ADDR_W(22), .DATA_W(32), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .hlt(hlt), .flush(flush),
    .MEM_mem_read(rd), .MEM_mem_write(wr),
    .MEM_ALU_result(alu), .MEM_store_data(sdata),
    .mem_req(req), .mem_we(we), .mem_addr(addr), .mem_wdata(wdata),
    .mem_ack(ack), .mem_rdata(rdata),
    .mem_stall(stall), .MEM_mem_result(result), .mem_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        hlt, flush, rd, wr, ack;
    logic [31:0] alu, sdata, rdata;
    logic        req, stall, err;
    logic        bus;     // check we/addr (and wdata for writes) this cycle
    logic        we;
    logic [21:0] eaddr;
    logic [31:0] ewdata;
    logic [31:0] eresult;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic h, input logic f, input logic r, input logic w,
                     input logic a, input logic [31:0] al, input logic [31:0] sd, input logic [31:0] rdd,
                     input logic ereq, input logic est, input logic eerr, input logic bus,
                     input logic ewe, input logic [21:0] ea, input logic [31:0] ewd, input logic [31:0] eres);
    vec_t v;
    v.name = n; v.hlt = h; v.flush = f; v.rd = r; v.wr = w; v.ack = a;
    v.alu = al; v.sdata = sd; v.rdata = rdd;
    v.req = ereq; v.stall = est; v.err = eerr; v.bus = bus; v.we = ewe;
    v.eaddr = ea; v.ewdata = ewd; v.eresult = eres;
    vq.push_back(v);
  endtask

  task automatic drive(input logic h, input logic f, input logic r, input logic w, input logic a,
                       input logic [31:0] al, input logic [31:0] sd, input logic [31:0] rdd);
    hlt = h; flush = f; rd = r; wr = w; ack = a; alu = al; sdata = sd; rdata = rdd;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    chk("reset_req",    {31'd0, req},    0);
    chk("reset_we",     {31'd0, we},     0);
    chk("reset_addr",   {10'd0, addr},   0);
    chk("reset_wdata",  wdata,           0);
    chk("reset_result", result,          0);
    chk("reset_err",    {31'd0, err},    0);
    chk("reset_stall",  {31'd0, stall},  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read, ack in first request cycle.
    add("rd0", 0,0,1,0,0, 32'h0000_1234,0,0,              0,1,0,0,0,0,0,0);
    add("rd1", 0,0,1,0,1, 32'h0000_1234,0,32'hCAFEBABE,   1,1,0,1,0,22'h001234,0,0);
    add("rd2", 0,0,1,0,0, 32'h0000_1234,0,0,              0,0,0,0,0,0,0,32'hCAFEBABE);
    add("rd3", 0,0,0,0,0, 0,0,0,                          0,0,0,0,0,0,0,32'hCAFEBABE);
    // Write, ack after four request cycles.
    add("wr0", 0,0,0,1,0, 32'h003F_FFFC,32'h12345678,0,   0,1,0,0,0,0,0,32'hCAFEBABE);
    add("wr1", 0,0,0,1,0, 32'h003F_FFFC,32'h12345678,0,   1,1,0,1,1,22'h3FFFFC,32'h12345678,32'hCAFEBABE);
    add("wr2", 0,0,0,1,0, 32'h003F_FFFC,32'h12345678,0,   1,1,0,1,1,22'h3FFFFC,32'h12345678,32'hCAFEBABE);
    add("wr3", 0,0,0,1,0, 32'h003F_FFFC,32'h12345678,0,   1,1,0,1,1,22'h3FFFFC,32'h12345678,32'hCAFEBABE);
    add("wr4", 0,0,0,1,1, 32'h003F_FFFC,32'h12345678,32'h55555555, 1,1,0,1,1,22'h3FFFFC,32'h12345678,32'hCAFEBABE);
    add("wr5", 0,0,0,1,0, 32'h003F_FFFC,32'h12345678,0,   0,0,0,0,0,0,0,32'hCAFEBABE);
    add("wr6", 0,0,0,0,0, 0,0,0,                          0,0,0,0,0,0,0,32'hCAFEBABE);
    // Flush in second BUSY cycle; result must not update, no DONE cycle.
    add("fl0", 0,0,1,0,0, 32'h0000_0040,0,0,              0,1,0,0,0,0,0,32'hCAFEBABE);
    add("fl1", 0,0,1,0,0, 32'h0000_0040,0,0,              1,1,0,1,0,22'h000040,0,32'hCAFEBABE);
    add("fl2", 0,1,1,0,0, 32'h0000_0040,0,0,              1,1,0,1,0,22'h000040,0,32'hCAFEBABE);
    add("fl3", 0,0,0,0,1, 0,0,32'hFFFFFFFF,               1,1,0,1,0,22'h000040,0,32'hCAFEBABE);
    add("fl4", 0,0,0,0,0, 0,0,0,                          0,0,0,0,0,0,0,32'hCAFEBABE);
    // hlt blocks start, then hlt raised mid-BUSY does not abort.
    add("hl0", 1,0,1,0,0, 32'h0000_0080,0,0,              0,0,0,0,0,0,0,32'hCAFEBABE);
    add("hl1", 1,0,1,0,0, 32'h0000_0080,0,0,              0,0,0,0,0,0,0,32'hCAFEBABE);
    add("hl2", 0,0,1,0,0, 32'h0000_0080,0,0,              0,1,0,0,0,0,0,32'hCAFEBABE);
    add("hl3", 1,0,1,0,0, 32'h0000_0080,0,0,              1,1,0,1,0,22'h000080,0,32'hCAFEBABE);
    add("hl4", 1,0,1,0,1, 32'h0000_0080,0,32'hA5A50F0F,   1,1,0,1,0,22'h000080,0,32'hCAFEBABE);
    add("hl5", 1,0,1,0,0, 32'h0000_0080,0,0,              0,0,0,0,0,0,0,32'hA5A50F0F);
    add("hl6", 0,0,0,0,0, 0,0,0,                          0,0,0,0,0,0,0,32'hA5A50F0F);

    foreach (vq[i]) begin
      @(posedge clk); #1;
      drive(vq[i].hlt, vq[i].flush, vq[i].rd, vq[i].wr, vq[i].ack, vq[i].alu, vq[i].sdata, vq[i].rdata);
      @(negedge clk);
      chk({vq[i].name, "_req"},    {31'd0, req},   {31'd0, vq[i].req});
      chk({vq[i].name, "_stall"},  {31'd0, stall}, {31'd0, vq[i].stall});
      chk({vq[i].name, "_err"},    {31'd0, err},   {31'd0, vq[i].err});
      chk({vq[i].name, "_result"}, result,         vq[i].eresult);
      if (vq[i].bus) begin
        chk({vq[i].name, "_we"},   {31'd0, we},    {31'd0, vq[i].we});
        chk({vq[i].name, "_addr"}, {10'd0, addr},  {10'd0, vq[i].eaddr});
        if (vq[i].we) chk({vq[i].name, "_wdata"}, wdata, vq[i].ewdata);
      end
    end

    // Timeout: read with no ack, request held 16 cycles then one error pulse.
    @(posedge clk); #1;
    drive(0, 0, 1, 0, 0, 32'h0000_0100, 0, 0);
    @(negedge clk);
    chk("to_start_stall", {31'd0, stall}, 1);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("to_req_c%0d", c), {31'd0, req}, 1);
      chk($sformatf("to_err_c%0d", c), {31'd0, err}, 0);
    end
    @(posedge clk); #1;
    rd = 1'b0;
    @(negedge clk);
    chk("to_req_drop",   {31'd0, req},   0);
    chk("to_err_pulse",  {31'd0, err},   1);
    chk("to_done_stall", {31'd0, stall}, 0);
    chk("to_result",     result,         32'hA5A50F0F);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_err_once",   {31'd0, err},   0);
    @(posedge clk); #1;
    ack = 1'b1; rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("late_ack_stall", {31'd0, stall}, 0);
    @(posedge clk); #1;
    ack = 1'b0; rdata = 0;
    @(negedge clk);
    chk("late_ack_result", result,        32'hA5A50F0F);
    chk("late_ack_req",    {31'd0, req},  0);
    chk("late_ack_err",    {31'd0, err},  0);

    // Asynchronous reset mid-BUSY, then a fresh read.
    @(posedge clk); #1;
    drive(0, 0, 1, 0, 0, 32'h0000_0200, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_busy_req", {31'd0, req}, 1);
    #2;
    rst_n = 1'b0; rd = 1'b0;
    #1;
    chk("rst_req",    {31'd0, req},   0);
    chk("rst_stall",  {31'd0, stall}, 0);
    chk("rst_addr",   {10'd0, addr},  0);
    chk("rst_result", result,         0);
    chk("rst_err",    {31'd0, err},   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 1, 0, 0, 32'h0000_0300, 0, 0);
    @(posedge clk); #1;
    ack = 1'b1; rdata = 32'h13579BDF;
    @(negedge clk);
    chk("post_rst_req",  {31'd0, req},  1);
    chk("post_rst_addr", {10'd0, addr}, 32'h0000_0300);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_req_low", {31'd0, req},   0);
    chk("post_rst_stall",   {31'd0, stall}, 0);
    chk("post_rst_result",  result,         32'h13579BDF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
